// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: definitions shared by the fetch unit and its PC adder.
//   fetch_state_e    : fetch FSM state encoding
//   pcsrc_e          : PC source select used by the PC adder
//   fetch_entry_t    : instruction word + its PC (one skid/output entry)
//   DEFAULT_RESET_PC : default reset vector
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'b00,
        ST_WAIT  = 2'b01,
        ST_HOLD  = 2'b10,
        ST_DRAIN = 2'b11
    } fetch_state_e;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_REL = 2'b01,
        PCSRC_ABS = 2'b10
    } pcsrc_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_skid_buf.sv
// fetch_skid_buf: one-entry buffer holding a fetched word and its PC while
// the decode-facing output register is occupied.
// Ports:
//   CLK, RST (sync, active-low)
//   load  : capture din (sets full)
//   pop   : release the entry (clears full)
//   clear : drop the entry; wins over load/pop
//   din / dout : {inst, pc} entry
//   full  : entry present
module fetch_skid_buf
    import pc_fetch_unit_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t din,
    output logic         full,
    output fetch_entry_t dout
);

    logic         full_q, full_d;
    fetch_entry_t data_q, data_d;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clear) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d = 1'b1;
            data_d = din;
        end else if (pop) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign full = full_q;
    assign dout = data_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the PC register, fetches from instruction memory with a
// req/gnt/rvalid handshake (one request outstanding) and hands words to
// decode over valid/ready. A one-entry skid buffer absorbs a response that
// lands while decode is stalled. The PC adder supplies nextPC; this block
// never does PC arithmetic itself.
// Ports:
//   CLK, RST (sync, active-low), RESET_PC parameter
//   nextPC in / currPC out          : PC adder loop
//   imem_req/addr out, imem_gnt/rvalid/rdata in : memory side
//   inst_valid/inst/inst_pc out, inst_ready in  : decode side
//   flush in                        : redirect, target arrives on nextPC
//   fault out                       : only when FETCH_ALIGN_CHECK_EN is defined
// Build option: FETCH_ALIGN_CHECK_EN stalls fetch on a misaligned PC and
// raises a sticky fault; otherwise the address is force-aligned.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] nextPC,
    output logic [31:0] currPC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        flush
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fault
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         ivld_q, ivld_d;
    fetch_entry_t out_q, out_d;

    logic         skid_load, skid_pop, skid_clear, skid_full;
    fetch_entry_t skid_dout;

    logic         req_ok;
    logic         req_w;
    logic         issued;
    logic         consumed;
    logic         out_free;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_d;
    assign req_ok    = (pc_q[1:0] == 2'b00);
    assign imem_addr = pc_q;
    assign fault     = fault_q;
`else
    assign req_ok    = 1'b1;
    assign imem_addr = {pc_q[31:2], 2'b00};
`endif

    // RST gates the request so it stays low for the whole reset window,
    // including the cycle before the first reset edge has been seen.
    assign req_w    = RST && (state_q == ST_REQ) && req_ok;
    assign imem_req = req_w;
    assign issued   = req_w && imem_gnt;
    assign consumed = ivld_q && inst_ready;
    assign out_free = !ivld_q || inst_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ivld_d     = consumed ? 1'b0 : ivld_q;
        out_d      = out_q;
        skid_load  = 1'b0;
        skid_pop   = 1'b0;
        skid_clear = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_d    = fault_q;
`endif

        case (state_q)
            ST_REQ: begin
`ifdef FETCH_ALIGN_CHECK_EN
                if (!req_ok) fault_d = 1'b1;
`endif
                if (issued) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    pc_d = nextPC;
                    if (out_free) begin
                        ivld_d  = 1'b1;
                        out_d   = '{inst: imem_rdata, pc: pc_q};
                        state_d = ST_REQ;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (consumed) begin
                    ivld_d   = 1'b1;
                    out_d    = skid_dout;
                    skid_pop = 1'b1;
                    state_d  = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (imem_rvalid) state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
        endcase

        // Redirect overrides everything above. A response still owed by
        // memory after this cycle must be swallowed in DRAIN.
        if (flush) begin
            pc_d       = nextPC;
            ivld_d     = 1'b0;
            skid_load  = 1'b0;
            skid_pop   = 1'b0;
            skid_clear = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_d    = 1'b0;
`endif
            case (state_q)
                ST_REQ:   state_d = issued ? ST_DRAIN : ST_REQ;
                ST_WAIT,
                ST_DRAIN: state_d = imem_rvalid ? ST_REQ : ST_DRAIN;
                default:  state_d = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            ivld_q  <= 1'b0;
            out_q   <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ivld_q  <= ivld_d;
            out_q   <= out_d;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q <= fault_d;
`endif
        end
    end

    fetch_skid_buf u_skid (
        .CLK   (CLK),
        .RST   (RST),
        .load  (skid_load),
        .pop   (skid_pop),
        .clear (skid_clear),
        .din   ('{inst: imem_rdata, pc: pc_q}),
        .full  (skid_full),
        .dout  (skid_dout)
    );

    assign currPC     = pc_q;
    assign inst_valid = ivld_q;
    assign inst       = out_q.inst;
    assign inst_pc    = out_q.pc;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a small instruction-memory model
// (grant when enabled, response one cycle later, data = 0xA5 : addr[23:0]
// unless forced to 0xDEADBEEF) and a PC adder returning currPC+4, or the
// flush target while flush is high.
module tb_pc_fetch_unit;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [31:0] RPC = 32'h0000_0102;
`else
    localparam logic [31:0] RPC = 32'h0000_0100;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] nextPC, currPC, imem_addr, imem_rdata, inst, inst_pc;
    logic        imem_req, imem_gnt, imem_rvalid, inst_valid;
    logic        inst_ready = 1'b1;
    logic        flush = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fault;
`endif

    logic        gnt_en = 1'b1, rv_en = 1'b1, bad = 1'b0;
    logic [31:0] tgt = 32'h0;
    logic        pend;
    logic [31:0] paddr;
    int          ngnt;
    int          n_cmp = 0, n_bad = 0;

    always #5 CLK = ~CLK;

    assign nextPC      = flush ? tgt : currPC + 32'd4;
    assign imem_gnt    = imem_req & gnt_en;
    assign imem_rvalid = pend & rv_en;
    assign imem_rdata  = bad ? 32'hDEAD_BEEF : {8'hA5, paddr[23:0]};

    always @(posedge CLK) begin
        if (!RST) begin
            pend  <= 1'b0;
            paddr <= '0;
            ngnt  <= 0;
        end else if (imem_req && imem_gnt) begin
            pend  <= 1'b1;
            paddr <= imem_addr;
            ngnt  <= ngnt + 1;
        end else if (imem_rvalid) begin
            pend  <= 1'b0;
        end
    end

    pc_fetch_unit #(.RESET_PC(RPC)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .nextPC      (nextPC),
        .currPC      (currPC),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .flush       (flush)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fault       (fault)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Hold reset for two edges, release at a falling edge.
    task automatic do_reset();
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        // Reset state, sampled while RST is still low.
        repeat (2) @(negedge CLK);
        chk("rst_pc",    currPC,     RPC);
        chk("rst_req",   imem_req,   32'd0);
        chk("rst_ivld",  inst_valid, 32'd0);
        chk("rst_inst",  inst,       32'd0);
        chk("rst_ipc",   inst_pc,    32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("rst_fault", fault,      32'd0);
        RST = 1'b1;
        #1;
        chk("al_noreq0", imem_req, 32'd0);
        @(negedge CLK);
        chk("al_fault",  fault,    32'd1);
        chk("al_noreq1", imem_req, 32'd0);
        chk("al_ngnt",   ngnt,     32'd0);
        flush = 1'b1; tgt = 32'h200;
        @(negedge CLK);
        flush = 1'b0;
        chk("al_fclr",   fault,     32'd0);
        chk("al_pc",     currPC,    32'h200);
        chk("al_req",    imem_req,  32'd1);
        chk("al_addr",   imem_addr, 32'h200);
        repeat (2) @(negedge CLK);
        chk("al_ivld",   inst_valid, 32'd1);
        chk("al_ipc",    inst_pc,    32'h200);
        chk("al_inst",   inst,       32'hA500_0200);
`else
        RST = 1'b1;
        #1;
        chk("rel_req",  imem_req,  32'd1);
        chk("rel_addr", imem_addr, 32'h100);

        // Sequential fetch, one word every other cycle.
        @(negedge CLK);
        chk("sq_v1", inst_valid, 32'd0);
        @(negedge CLK);
        chk("sq_v2",   inst_valid, 32'd1);
        chk("sq_pc0",  inst_pc,    32'h100);
        chk("sq_ins0", inst,       32'hA500_0100);
        @(negedge CLK);
        chk("sq_v3",   inst_valid, 32'd0);
        @(negedge CLK);
        chk("sq_v4",   inst_valid, 32'd1);
        chk("sq_pc1",  inst_pc,    32'h104);
        repeat (2) @(negedge CLK);
        chk("sq_v6",   inst_valid, 32'd1);
        chk("sq_pc2",  inst_pc,    32'h108);
        chk("sq_cpc",  currPC,     32'h10C);

        // Backpressure: second word parks in the skid, no third request.
        inst_ready = 1'b0;
        do_reset();
        repeat (6) @(negedge CLK);
        chk("bp_req",  imem_req,   32'd0);
        chk("bp_ngnt", ngnt,       32'd2);
        chk("bp_ivld", inst_valid, 32'd1);
        chk("bp_pc0",  inst_pc,    32'h100);
        chk("bp_cpc",  currPC,     32'h108);
        inst_ready = 1'b1;
        @(negedge CLK);
        chk("bp_ivld1", inst_valid, 32'd1);
        chk("bp_pc1",   inst_pc,    32'h104);
        chk("bp_ins1",  inst,       32'hA500_0104);
        chk("bp_addr",  imem_addr,  32'h108);
        repeat (2) @(negedge CLK);
        chk("bp_pc2",   inst_pc,    32'h108);

        // Flush while waiting for a response.
        do_reset();
        @(negedge CLK);
        rv_en = 1'b0; flush = 1'b1; tgt = 32'h400;
        @(negedge CLK);
        flush = 1'b0; rv_en = 1'b1; bad = 1'b1;
        chk("fw_req",  imem_req, 32'd0);
        chk("fw_pc",   currPC,   32'h400);
        @(negedge CLK);
        bad = 1'b0;
        chk("fw_ivld", inst_valid, 32'd0);
        chk("fw_pcd",  currPC,     32'h400);
        chk("fw_addr", imem_addr,  32'h400);
        repeat (2) @(negedge CLK);
        chk("fw_ipc",  inst_pc,    32'h400);
        chk("fw_ins",  inst,       32'hA500_0400);

        // Flush in REQ with a same-cycle grant -> one response drained.
        flush = 1'b1; tgt = 32'h800;
        @(negedge CLK);
        flush = 1'b0; bad = 1'b1;
        chk("fr_req",  imem_req,   32'd0);
        chk("fr_ivld", inst_valid, 32'd0);
        chk("fr_pc",   currPC,     32'h800);
        @(negedge CLK);
        bad = 1'b0;
        chk("fr_pcd",  currPC,     32'h800);
        chk("fr_req1", imem_req,   32'd1);
        chk("fr_addr", imem_addr,  32'h800);
        chk("fr_ivd1", inst_valid, 32'd0);
        repeat (2) @(negedge CLK);
        chk("fr_ipc",  inst_pc,    32'h800);
        chk("fr_ins",  inst,       32'hA500_0800);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
